// File: rtl/ip_tx_packetizer.sv
// Framer from the TX byte FIFO to the IP TX header/payload interface: parses a 12-byte
// descriptor, issues one header handshake, streams the payload with tlast, drops illegal lengths.
module ip_tx_packetizer #(
    parameter int          MAX_PAYLOAD = 1480,
    parameter logic [5:0]  DSCP        = 6'd0,
    parameter logic [1:0]  ECN         = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        tx_ip_hdr_valid,
    input  logic        tx_ip_hdr_ready,
    output logic [5:0]  tx_ip_dscp,
    output logic [1:0]  tx_ip_ecn,
    output logic [15:0] tx_ip_length,
    output logic [7:0]  tx_ip_ttl,
    output logic [7:0]  tx_ip_protocol,
    output logic [31:0] tx_ip_source_ip,
    output logic [31:0] tx_ip_dest_ip,
    output logic [7:0]  tx_ip_payload_axis_tdata,
    output logic        tx_ip_payload_axis_tvalid,
    input  logic        tx_ip_payload_axis_tready,
    output logic        tx_ip_payload_axis_tlast,
    output logic [15:0] drop_count,
    output logic [1:0]  dbg_state
);

    // Handshakes: a header or payload beat transfers on a rising edge where valid && ready;
    // valid never depends on ready, and the offered values hold until the transfer.

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_HOUT = 2'd1,
        S_PAY  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] dest_q, dest_d;
    logic [31:0] src_q, src_d;
    logic [7:0]  proto_q, proto_d;
    logic [7:0]  ttl_q, ttl_d;
    logic [15:0] len_q, len_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] drop_q, drop_d;
    logic [15:0] len_full;

    // Length as it stands once the 12th descriptor byte (low length byte) is at the FIFO head.
    assign len_full = {len_q[7:0], fifo_dout};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HDR;
            idx_q   <= 4'd0;
            dest_q  <= 32'd0;
            src_q   <= 32'd0;
            proto_q <= 8'd0;
            ttl_q   <= 8'd0;
            len_q   <= 16'd0;
            rem_q   <= 16'd0;
            drop_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            proto_q <= proto_d;
            ttl_q   <= ttl_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dest_d     = dest_q;
        src_d      = src_q;
        proto_d    = proto_q;
        ttl_d      = ttl_q;
        len_d      = len_q;
        rem_d      = rem_q;
        drop_d     = drop_q;
        fifo_rd_en = 1'b0;
        tx_ip_hdr_valid           = 1'b0;
        tx_ip_payload_axis_tvalid = 1'b0;
        tx_ip_payload_axis_tlast  = 1'b0;

        unique case (state_q)
            S_HDR: begin
                fifo_rd_en = ~fifo_empty;
                if (!fifo_empty) begin
                    // Multi-byte fields arrive MSB first, so shift each byte in from the right.
                    if (idx_q <= 4'd3)      dest_d  = {dest_q[23:0], fifo_dout};
                    else if (idx_q <= 4'd7) src_d   = {src_q[23:0], fifo_dout};
                    else if (idx_q == 4'd8) proto_d = fifo_dout;
                    else if (idx_q == 4'd9) ttl_d   = fifo_dout;
                    else                    len_d   = len_full;

                    if (idx_q == 4'd11) begin
                        idx_d = 4'd0;
                        if (len_full == 16'd0) begin
                            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                        end else if (len_full > MAX_LEN) begin
                            rem_d   = len_full;
                            state_d = S_DROP;
                        end else begin
                            state_d = S_HOUT;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_HOUT: begin
                tx_ip_hdr_valid = 1'b1;
                if (tx_ip_hdr_ready) begin
                    rem_d   = len_q;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                tx_ip_payload_axis_tvalid = ~fifo_empty;
                tx_ip_payload_axis_tlast  = (rem_q == 16'd1);
                fifo_rd_en = ~fifo_empty & tx_ip_payload_axis_tready;
                if (fifo_rd_en) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_HDR;
                end
            end
            S_DROP: begin
                fifo_rd_en = ~fifo_empty;
                if (!fifo_empty) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_HDR;
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    assign tx_ip_dscp               = DSCP;
    assign tx_ip_ecn                = ECN;
    assign tx_ip_length             = len_q + 16'd20;
    assign tx_ip_ttl                = ttl_q;
    assign tx_ip_protocol           = proto_q;
    assign tx_ip_source_ip          = src_q;
    assign tx_ip_dest_ip            = dest_q;
    assign tx_ip_payload_axis_tdata = fifo_dout;
    assign drop_count               = drop_q;
    assign dbg_state                = state_q;

endmodule

// File: tb/tb_ip_tx_packetizer.sv
// Bench for ip_tx_packetizer: a queue-based FIFO, a packet-level model of expected headers,
// payload beats and drops, and one negedge compare process.
module tb_ip_tx_packetizer;
  localparam int MAX_PAYLOAD = 1480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        tx_ip_hdr_valid;
  logic        tx_ip_hdr_ready = 1'b1;
  logic [5:0]  tx_ip_dscp;
  logic [1:0]  tx_ip_ecn;
  logic [15:0] tx_ip_length;
  logic [7:0]  tx_ip_ttl;
  logic [7:0]  tx_ip_protocol;
  logic [31:0] tx_ip_source_ip;
  logic [31:0] tx_ip_dest_ip;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic [15:0] drop_count;
  logic [1:0]  dbg_state;

  ip_tx_packetizer #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
    .clk(clk), .rst(rst),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .tx_ip_hdr_valid(tx_ip_hdr_valid), .tx_ip_hdr_ready(tx_ip_hdr_ready),
    .tx_ip_dscp(tx_ip_dscp), .tx_ip_ecn(tx_ip_ecn), .tx_ip_length(tx_ip_length),
    .tx_ip_ttl(tx_ip_ttl), .tx_ip_protocol(tx_ip_protocol),
    .tx_ip_source_ip(tx_ip_source_ip), .tx_ip_dest_ip(tx_ip_dest_ip),
    .tx_ip_payload_axis_tdata(tdata), .tx_ip_payload_axis_tvalid(tvalid),
    .tx_ip_payload_axis_tready(tready), .tx_ip_payload_axis_tlast(tlast),
    .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  logic [7:0]  fifo_mem[$];
  logic [95:0] exp_hdr_q[$];
  logic [8:0]  exp_q[$];
  int          exp_drops = 0;
  int          hdr_cnt = 0, beat_cnt = 0;
  logic [95:0] last_hdr = '0;
  logic [8:0]  last_beat = '0;

  // FIFO / sink driver controls
  bit pop_now = 1'b0;
  int pop_cnt = 0, gap_at = -1, gap_len = 0, stall_cnt = 0;
  bit tog_mode = 1'b0;
  int hdr_delay = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic upd();
    fifo_empty = (fifo_mem.size() == 0) || (stall_cnt > 0);
    fifo_dout  = (fifo_mem.size() != 0) ? fifo_mem[0] : 8'h00;
  endtask

  // FIFO pop, stall injection and ready patterns, all applied 1 time unit after the edge
  always @(negedge clk) pop_now = fifo_rd_en && !fifo_empty;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      fifo_mem.delete();
      stall_cnt = 0;
    end else begin
      if (stall_cnt > 0) stall_cnt--;
      if (pop_now) begin
        void'(fifo_mem.pop_front());
        pop_cnt++;
        if (pop_cnt == gap_at) stall_cnt = gap_len;
      end
    end
    upd();
    tready = tog_mode ? ~tready : 1'b1;
    if (hdr_delay > 0 && tx_ip_hdr_valid) hdr_delay--;
    tx_ip_hdr_ready = (hdr_delay == 0);
  end

  // driver: push one descriptor + payload and record what must come out
  task automatic add_pkt(input logic [31:0] dst, input logic [31:0] src, input logic [7:0] proto,
                         input logic [7:0] ttl, input logic [15:0] len,
                         input logic [7:0] first, input logic [7:0] step);
    logic [7:0] b;
    bit fwd;
    fwd = (len != 16'd0) && (int'(len) <= MAX_PAYLOAD);
    for (int i = 3; i >= 0; i--) fifo_mem.push_back(dst[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fifo_mem.push_back(src[i*8 +: 8]);
    fifo_mem.push_back(proto);
    fifo_mem.push_back(ttl);
    fifo_mem.push_back(len[15:8]);
    fifo_mem.push_back(len[7:0]);
    if (fwd) exp_hdr_q.push_back({dst, src, proto, ttl, 16'(int'(len) + 20)});
    else exp_drops++;
    for (int i = 0; i < int'(len); i++) begin
      b = first + 8'(i) * step;
      fifo_mem.push_back(b);
      if (fwd) exp_q.push_back({(i == int'(len) - 1), b});
    end
    upd();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fifo_mem.size() == 0 && exp_hdr_q.size() == 0 && exp_q.size() == 0 &&
          !tx_ip_hdr_valid && !tvalid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("timeout", 96'd0, 96'd1);
    repeat (2) tick();
  endtask

  task automatic clear_counts();
    hdr_cnt = 0;
    beat_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_hdr_valid", 96'(tx_ip_hdr_valid), 96'd0);
    chk("rst_tvalid", 96'(tvalid), 96'd0);
    chk("rst_tlast", 96'(tlast), 96'd0);
    chk("rst_rd_en", 96'(fifo_rd_en), 96'd0);
    chk("rst_drop_count", 96'(drop_count), 96'd0);
    chk("rst_hdr_fields", {tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol, tx_ip_ttl, tx_ip_length},
        {32'd0, 32'd0, 8'd0, 8'd0, 16'd20});
  endtask

  // scoreboard: compare process on the falling edge
  logic [95:0] cur_hdr, prev_hdr = '0;
  bit prev_hv = 0, prev_hr = 0, prev_tv = 0, prev_tr = 0;
  logic [8:0] prev_beat = '0;
  logic [95:0] e_hdr;
  logic [8:0]  e_beat;

  always @(negedge clk) begin
    cur_hdr = {tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol, tx_ip_ttl, tx_ip_length};
    if (!rst) begin
      if (tx_ip_hdr_valid) begin
        if (prev_hv && !prev_hr) chk("hdr_hold", cur_hdr, prev_hdr);
        if (fifo_rd_en) chk("hout_pop", 96'(fifo_rd_en), 96'd0);
        if (tx_ip_hdr_ready) begin
          if (exp_hdr_q.size() == 0) chk("unexpected_hdr", 96'd1, 96'd0);
          else begin
            e_hdr = exp_hdr_q.pop_front();
            chk("hdr_fields", cur_hdr, e_hdr);
            chk("hdr_dscp_ecn", 96'({tx_ip_dscp, tx_ip_ecn}), 96'd0);
          end
          last_hdr = cur_hdr;
          hdr_cnt++;
        end
      end
      if (tvalid) begin
        if (fifo_empty) chk("tvalid_while_empty", 96'(tvalid), 96'd0);
        if (prev_tv && !prev_tr) chk("beat_hold", 96'({tlast, tdata}), 96'(prev_beat));
        if (tready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 96'd1, 96'd0);
          else begin
            e_beat = exp_q.pop_front();
            chk("beat", 96'({tlast, tdata}), 96'(e_beat));
          end
          last_beat = {tlast, tdata};
          beat_cnt++;
        end
      end
      if (stall_cnt > 0) chk("gap_tvalid", 96'(tvalid), 96'd0);
    end
    prev_hdr  = cur_hdr;
    prev_hv   = tx_ip_hdr_valid;
    prev_hr   = tx_ip_hdr_ready;
    prev_tv   = tvalid;
    prev_tr   = tready;
    prev_beat = {tlast, tdata};
  end

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) tick();
    exp_hdr_q.delete(); exp_q.delete(); exp_drops = 0;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // basic packet, sink always ready
    clear_counts();
    add_pkt(32'hC0A80102, 32'hC0A80180, 8'h11, 8'h40, 16'd4, 8'hAA, 8'h11);
    wait_done(200);
    chk("t1_hdr_literal", last_hdr, {32'hC0A80102, 32'hC0A80180, 8'h11, 8'h40, 16'd24});
    chk("t1_last_beat", 96'(last_beat), 96'h1DD);
    chk("t1_counts", 96'({16'(hdr_cnt), 16'(beat_cnt)}), 96'({16'd1, 16'd4}));

    // header back-pressure and toggling tready
    clear_counts();
    hdr_delay = 5; tx_ip_hdr_ready = 1'b0; tog_mode = 1'b1;
    add_pkt(32'hC0A80102, 32'hC0A80180, 8'h11, 8'h40, 16'd4, 8'hAA, 8'h11);
    wait_done(200);
    tog_mode = 1'b0;
    chk("t2_counts", 96'({16'(hdr_cnt), 16'(beat_cnt)}), 96'({16'd1, 16'd4}));

    // oversize packet dropped, then a 2-byte packet
    clear_counts();
    add_pkt(32'h0A000001, 32'h0A000002, 8'h06, 8'h20, 16'h05C9, 8'h01, 8'h01);
    add_pkt(32'h0A000003, 32'h0A000004, 8'h06, 8'h21, 16'd2, 8'h55, 8'hAA);
    wait_done(3000);
    chk("t3_drop_literal", 96'(drop_count), 96'd1);
    chk("t3_hdr_literal", last_hdr, {32'h0A000003, 32'h0A000004, 8'h06, 8'h21, 16'd22});
    chk("t3_last_beat", 96'(last_beat), 96'h1FF);
    chk("t3_counts", 96'({16'(hdr_cnt), 16'(beat_cnt)}), 96'({16'd1, 16'd2}));

    // zero-length descriptor followed directly by a valid packet
    clear_counts();
    add_pkt(32'h01020304, 32'h05060708, 8'h11, 8'h01, 16'd0, 8'h00, 8'h00);
    add_pkt(32'h11223344, 32'h55667788, 8'h01, 8'h7F, 16'd3, 8'h10, 8'h01);
    wait_done(200);
    chk("t4_drop_literal", 96'(drop_count), 96'd2);
    chk("t4_hdr_literal", last_hdr, {32'h11223344, 32'h55667788, 8'h01, 8'h7F, 16'd23});
    chk("t4_counts", 96'({16'(hdr_cnt), 16'(beat_cnt)}), 96'({16'd1, 16'd3}));

    // FIFO empty for 3 cycles after payload byte 2
    clear_counts();
    pop_cnt = 0; gap_at = 14; gap_len = 3;
    add_pkt(32'hC0A80102, 32'hC0A80180, 8'h11, 8'h40, 16'd4, 8'hAA, 8'h11);
    wait_done(200);
    gap_at = -1;
    chk("t5_counts", 96'({16'(hdr_cnt), 16'(beat_cnt)}), 96'({16'd1, 16'd4}));

    // reset after payload byte 1, then a fresh packet
    clear_counts();
    pop_cnt = 0;
    add_pkt(32'hC0A80102, 32'hC0A80180, 8'h11, 8'h40, 16'd4, 8'hAA, 8'h11);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (pop_cnt >= 13) begin hit = 1'b1; break; end
      end
      if (!hit) chk("t6_reach_pay", 96'd0, 96'd1);
    end
    rst = 1'b1;
    tick();
    exp_hdr_q.delete(); exp_q.delete(); exp_drops = 0;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    tick();
    clear_counts();
    add_pkt(32'hAC100001, 32'hAC100002, 8'h11, 8'h08, 16'd2, 8'h3C, 8'h01);
    wait_done(200);
    chk("t6_hdr_literal", last_hdr, {32'hAC100001, 32'hAC100002, 8'h11, 8'h08, 16'd22});
    chk("t6_counts", 96'({16'(hdr_cnt), 16'(beat_cnt)}), 96'({16'd1, 16'd2}));
    chk("t6_drop", 96'(drop_count), 96'd0);

    // length boundaries: 1 and MAX_PAYLOAD are forwarded
    clear_counts();
    add_pkt(32'h0A0A0A0A, 32'h0B0B0B0B, 8'h11, 8'h02, 16'd1, 8'h77, 8'h00);
    add_pkt(32'h0C0C0C0C, 32'h0D0D0D0D, 8'h06, 8'h03, 16'd1480, 8'h00, 8'h03);
    wait_done(3000);
    chk("t7_hdr_literal", last_hdr, {32'h0C0C0C0C, 32'h0D0D0D0D, 8'h06, 8'h03, 16'd1500});
    chk("t7_counts", 96'({16'(hdr_cnt), 16'(beat_cnt)}), 96'({16'd2, 16'd1481}));
    chk("t7_drop_model", 96'(drop_count), 96'(exp_drops));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
